// File: rtl/morse_pkg.sv
// Shared Morse definitions: key-timer FSM states and unit-counter sizing.
// Also used by the decoder for its symbol-pulse conventions.
package morse_pkg;

  typedef enum logic [1:0] {
    WAIT_UP,
    IDLE,
    PRESS,
    GAP
  } key_state_t;

  localparam int WORD_GAP_DEFAULT = 7;
  localparam int UNIT_W = $clog2(WORD_GAP_DEFAULT + 1);

  // Unit-counter width for a non-default word gap.
  function automatic int unit_width(input int word_gap);
    return $clog2(word_gap + 1);
  endfunction

endpackage

// File: rtl/morse_debounce.sv
// Key input conditioning: 2-flop synchroniser, then an optional debouncer.
// The debouncer is built only when MORSE_DEBOUNCE_EN is defined.
module morse_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key,
  output logic key_c
);

  logic [1:0] sync_reg;
  logic       key_s;

  // Reset to "pressed" so the FSM only leaves WAIT_UP after a real release.
  always_ff @(posedge Clock) begin
    if (Reset) sync_reg <= 2'b11;
    else       sync_reg <= {sync_reg[0], key};
  end

  assign key_s = sync_reg[1];

`ifdef MORSE_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [DEB_W-1:0] deb_cnt_reg;
  logic             key_c_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      key_c_reg   <= 1'b1;
      deb_cnt_reg <= '0;
    end else if (key_s == key_c_reg) begin
      deb_cnt_reg <= '0;
    end else if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
      key_c_reg   <= key_s;
      deb_cnt_reg <= '0;
    end else begin
      deb_cnt_reg <= deb_cnt_reg + 1'b1;
    end
  end

  assign key_c = key_c_reg;
`else
  assign key_c = key_s;
`endif

endmodule

// File: rtl/morse_key_timer.sv
// Morse key timer: turns a raw key level into dot/dash and letter/word gap pulses.
// Define MORSE_DEBOUNCE_EN to insert the debouncer in the key path.
module morse_key_timer
  import morse_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int DASH_MIN   = 3,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7,
  parameter int DEB_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key,
  output logic dot,
  output logic dash,
  output logic letter_done,
  output logic word_done,
  output logic keying
);

  localparam int CNT_W = unit_width(WORD_GAP);
  localparam int DIV_W = $clog2(TICK_DIV);

  logic             key_c;
  key_state_t       state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] unit_reg, unit_next, unit_eff;
  logic             tick;
  logic             sym_pending_reg, sym_pending_next;
  logic             let_pending_reg, let_pending_next;
  logic             dot_reg, dot_next, dash_reg, dash_next;
  logic             letter_reg, letter_next, word_reg, word_next;
  logic             keying_reg, keying_next;

  morse_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .Clock (Clock),
    .Reset (Reset),
    .key   (key),
    .key_c (key_c)
  );

  // unit_eff includes the tick landing on this edge, so a state held N cycles
  // is judged on floor(N/TICK_DIV) units at the edge it is left.
  assign tick     = (div_reg == DIV_W'(TICK_DIV - 1));
  assign unit_eff = (tick && unit_reg != CNT_W'(WORD_GAP)) ? unit_reg + 1'b1 : unit_reg;

  always_comb begin
    state_next       = state_reg;
    div_next         = tick ? '0 : div_reg + 1'b1;
    unit_next        = unit_eff;
    sym_pending_next = sym_pending_reg;
    let_pending_next = let_pending_reg;
    dot_next         = 1'b0;
    dash_next        = 1'b0;
    letter_next      = 1'b0;
    word_next        = 1'b0;

    case (state_reg)
      WAIT_UP: if (!key_c) state_next = IDLE;
      IDLE:    if (key_c) state_next = PRESS;
      PRESS: begin
        if (!key_c) begin
          state_next = GAP;
          if (unit_eff >= CNT_W'(DASH_MIN)) dash_next = 1'b1;
          else if (unit_eff != '0)          dot_next  = 1'b1;
        end
      end
      GAP: begin
        // A new press wins over a gap boundary on the same edge.
        if (key_c) begin
          state_next = PRESS;
        end else if (tick && unit_eff == CNT_W'(LETTER_GAP)) begin
          letter_next = sym_pending_reg;
        end else if (tick && unit_eff == CNT_W'(WORD_GAP)) begin
          word_next  = let_pending_reg;
          state_next = IDLE;
        end
      end
      default: state_next = WAIT_UP;
    endcase

    if (dot_next || dash_next) sym_pending_next = 1'b1;
    if (letter_next) begin
      sym_pending_next = 1'b0;
      let_pending_next = 1'b1;
    end
    if (word_next) let_pending_next = 1'b0;

    if (state_next != state_reg) begin
      div_next  = '0;
      unit_next = '0;
    end
    keying_next = (state_next == PRESS);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg       <= WAIT_UP;
      div_reg         <= '0;
      unit_reg        <= '0;
      sym_pending_reg <= 1'b0;
      let_pending_reg <= 1'b0;
      dot_reg         <= 1'b0;
      dash_reg        <= 1'b0;
      letter_reg      <= 1'b0;
      word_reg        <= 1'b0;
      keying_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      div_reg         <= div_next;
      unit_reg        <= unit_next;
      sym_pending_reg <= sym_pending_next;
      let_pending_reg <= let_pending_next;
      dot_reg         <= dot_next;
      dash_reg        <= dash_next;
      letter_reg      <= letter_next;
      word_reg        <= word_next;
      keying_reg      <= keying_next;
    end
  end

  assign dot         = dot_reg;
  assign dash        = dash_reg;
  assign letter_done = letter_reg;
  assign word_done   = word_reg;
  assign keying      = keying_reg;

endmodule

// File: tb/tb_morse_key_timer.sv
// Scoreboard bench for morse_key_timer: stimulus queues timed events, a monitor checks them.
// Build with MORSE_DEBOUNCE_EN to run the debounced scenarios instead.
module tb_morse_key_timer;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic key   = 1'b0;
  logic dot, dash, letter_done, word_done, keying;

  always #5 Clock = ~Clock;

  morse_key_timer dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .key         (key),
    .dot         (dot),
    .dash        (dash),
    .letter_done (letter_done),
    .word_done   (word_done),
    .keying      (keying)
  );

  typedef enum int {EV_KUP, EV_KDN, EV_DOT, EV_DASH, EV_LET, EV_WORD} ev_t;
  typedef struct {
    ev_t kind;
    int  cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

`ifdef MORSE_DEBOUNCE_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 3;
`endif
  localparam int LET_DLY  = 12;
  localparam int WORD_DLY = 28;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic push(input ev_t kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input ev_t kind);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got %s at cycle %0d, required no event", kind.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                 kind.name(), cyc, e.kind.name(), e.cyc);
      end else begin
        $display("ok   %s at cycle %0d", kind.name(), cyc);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    logic [4:0] v;
    v = {dot, dash, letter_done, word_done, keying};
    n_checks++;
    if (v !== 5'b0) begin
      n_fail++;
      $display("FAIL %s: outputs {dot,dash,let,word,keying}=%b, required 00000", tag, v);
    end else begin
      $display("ok   %s outputs all zero at cycle %0d", tag, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // One key press of len cycles followed by gap cycles of silence.
  task automatic press(input int len, input int gap, input bit has_sym, input ev_t sym,
                       input bit exp_let, input bit exp_word, input bit exp_key);
    int r;
    if (exp_key) push(EV_KUP, cyc + LAT);
    key = 1'b1;
    wait_cycles(len);
    key = 1'b0;
    r   = cyc;
    if (exp_key)  push(EV_KDN, r + LAT);
    if (has_sym)  push(sym, r + LAT);
    if (exp_let)  push(EV_LET, r + LAT + LET_DLY);
    if (exp_word) push(EV_WORD, r + LAT + WORD_DLY);
    wait_cycles(gap);
  endtask

  initial begin : monitor
    logic prev_k;
    int   hot;
    prev_k = 1'b0;
    forever begin
      @(negedge Clock);
      if (keying !== prev_k) begin
        check_event(keying ? EV_KUP : EV_KDN);
        prev_k = keying;
      end
      hot = int'(dot) + int'(dash) + int'(letter_done) + int'(word_done);
      if (hot > 1) begin
        n_checks++;
        n_fail++;
        $display("FAIL exclusive: %0d pulses high at cycle %0d, required at most 1", hot, cyc);
      end
      if (dot)         check_event(EV_DOT);
      if (dash)        check_event(EV_DASH);
      if (letter_done) check_event(EV_LET);
      if (word_done)   check_event(EV_WORD);
    end
  end

  initial begin : stimulus
    int e;
    @(posedge Clock);
    #1;
    wait_cycles(4);
    check_zero("reset");
    Reset = 1'b0;
    wait_cycles(40);

`ifdef MORSE_DEBOUNCE_EN
    press(10, 40, 1'b0, EV_DOT, 1'b0, 1'b0, 1'b0);   // filtered glitch
    press(40, 60, 1'b1, EV_DASH, 1'b1, 1'b1, 1'b1);  // 10 units
    press(24, 60, 1'b1, EV_DASH, 1'b1, 1'b1, 1'b1);  // 6 units
`else
    press(8, 40, 1'b1, EV_DOT, 1'b1, 1'b1, 1'b1);
    press(12, 40, 1'b1, EV_DASH, 1'b1, 1'b1, 1'b1);
    press(11, 40, 1'b1, EV_DOT, 1'b1, 1'b1, 1'b1);
    press(3, 40, 1'b0, EV_DOT, 1'b0, 1'b0, 1'b1);    // 0 units, nothing pending
    press(8, 8, 1'b1, EV_DOT, 1'b0, 1'b0, 1'b1);
    press(12, 40, 1'b1, EV_DASH, 1'b1, 1'b1, 1'b1);
    // Next press lands exactly on the letter-gap edge, then one edge later.
    press(8, 12, 1'b1, EV_DOT, 1'b0, 1'b0, 1'b1);
    press(8, 13, 1'b1, EV_DOT, 1'b1, 1'b0, 1'b1);
    press(40, 40, 1'b1, EV_DASH, 1'b1, 1'b1, 1'b1);  // saturated count

    // Reset mid-press: press is dropped until the key is seen released.
    e = cyc;
    push(EV_KUP, e + LAT);
    key = 1'b1;
    wait_cycles(6);
    Reset = 1'b1;
    push(EV_KDN, e + 7);
    wait_cycles(1);
    check_zero("mid_press_reset");
    Reset = 1'b0;
    wait_cycles(40);
    key = 1'b0;
    wait_cycles(40);
    press(8, 40, 1'b1, EV_DOT, 1'b1, 1'b1, 1'b1);
`endif

    wait_cycles(20);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
